fabric_temporal_mux: RTL and testbench

Tag-inserting time-multiplexer. It is the transmit side of the tagged temporal-switch protocol.
- Merges NUM_INPUTS untagged streams into one tagged stream. Each accepted word is stamped with its lane's configured tag.
- Sits in front of temporal switches and temporal PEs.
- Round-robin arbitration across lanes; 2-entry output buffer; sticky error reporting.

---
 rtl/fabric_temporal_mux_if.sv | 32 +++
 rtl/fabric_temporal_mux.sv | 191 +++++++++++++++++++
 tb/tb_fabric_temporal_mux.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fabric_temporal_mux_if.sv
// Handshake bundle for fabric_temporal_mux: lane inputs, tagged output,
// static lane config and sticky error report.
interface fabric_temporal_mux_if #(
  parameter int NUM_INPUTS = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 4
) ();
  localparam int PW = DATA_WIDTH + TAG_WIDTH;
  localparam int CW = NUM_INPUTS * (1 + TAG_WIDTH);

  logic [NUM_INPUTS-1:0]            in_valid;
  logic [NUM_INPUTS-1:0]            in_ready;
  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data;
  logic                             out_valid;
  logic                             out_ready;
  logic [PW-1:0]                    out_data;
  logic [CW-1:0]                    cfg_data;
  logic                             error_valid;
  logic [15:0]                      error_code;

  modport slave (
    input  in_valid, in_data, out_ready, cfg_data,
    output in_ready, out_valid, out_data,
    output error_valid, error_code
  );

  modport master (
    output in_valid, in_data, out_ready, cfg_data,
    input  in_ready, out_valid, out_data,
    input  error_valid, error_code
  );
endinterface

// File: rtl/fabric_temporal_mux.sv
// Tag-inserting round-robin time-mux: NUM_INPUTS untagged lanes -> one
// tagged stream via 2-entry buffer. Ports: clk, rst_n (async low), bus.
module fabric_temporal_mux #(
  parameter int NUM_INPUTS = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fabric_temporal_mux_if.slave  bus
);

  localparam int PW = DATA_WIDTH + TAG_WIDTH;
  localparam int EW = 1 + TAG_WIDTH;
  localparam int RR_PTR_W =
    (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

  // Values mirror fabric_common.svh; CFG codes sit below RT codes.
  localparam logic [15:0] CFG_TEMPORAL_MUX_DUP_TAG = 16'h0021;
  localparam logic [15:0] RT_TEMPORAL_MUX_DISABLED_INPUT = 16'h1021;

  if (NUM_INPUTS < 1) begin : g_bad_n
    $fatal(1, "COMP_TEMPORAL_MUX_NUM_INPUTS");
  end
  if (DATA_WIDTH < 1) begin : g_bad_d
    $fatal(1, "COMP_TEMPORAL_MUX_DATA_WIDTH");
  end
  if (TAG_WIDTH < 1) begin : g_bad_t
    $fatal(1, "COMP_TEMPORAL_MUX_TAG_WIDTH");
  end

  typedef enum logic [1:0] {
    S_EMPTY,
    S_ONE,
    S_FULL
  } buf_state_t;

  buf_state_t r_state;
  buf_state_t w_state_nxt;

  logic [NUM_INPUTS-1:0] w_en;
  logic [NUM_INPUTS-1:0] w_elig;
  logic [TAG_WIDTH-1:0]  w_tag  [NUM_INPUTS];
  logic [DATA_WIDTH-1:0] w_lane [NUM_INPUTS];

  logic [RR_PTR_W-1:0] r_rr_ptr;
  logic [RR_PTR_W-1:0] w_rr_nxt;
  logic [RR_PTR_W-1:0] w_win;
  logic                w_found;
  logic                w_space;
  logic                w_grant;
  logic                w_pop;
  logic [PW-1:0]       w_word;

  logic w_ld0_new;
  logic w_ld1_new;
  logic w_ld0_q1;

  logic [PW-1:0] r_q0;
  logic [PW-1:0] r_q1;

  logic        w_dup;
  logic        w_dis;
  logic        w_err;
  logic [15:0] w_err_code;
  logic        r_err_valid;
  logic [15:0] r_err_code;

  for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_lane
    assign w_en[g]   = bus.cfg_data[g*EW + TAG_WIDTH];
    assign w_tag[g]  = bus.cfg_data[g*EW +: TAG_WIDTH];
    assign w_lane[g] = bus.in_data[g*DATA_WIDTH +: DATA_WIDTH];
    assign bus.in_ready[g] =
      w_grant && (w_win == RR_PTR_W'(g));
  end

  assign w_elig  = bus.in_valid & w_en;
  assign w_space = (r_state != S_EMPTY) ? (r_state == S_ONE) : 1'b1;
  // rst_n gate keeps every lane stalled while reset is held.
  assign w_grant = w_found && w_space && rst_n;
  assign w_word  = {w_tag[w_win], w_lane[w_win]};

  // First eligible lane at or after r_rr_ptr, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      int idx;
      idx = int'(r_rr_ptr) + k;
      if (idx >= NUM_INPUTS) idx = idx - NUM_INPUTS;
      if (!w_found && w_elig[idx]) begin
        w_found = 1'b1;
        w_win   = RR_PTR_W'(idx);
      end
    end
  end

  always_comb begin
    w_rr_nxt = w_win + 1'b1;
    if (NUM_INPUTS == 1 ||
        w_win == RR_PTR_W'(NUM_INPUTS - 1))
      w_rr_nxt = '0;
  end

  assign bus.out_valid = (r_state != S_EMPTY);
  assign bus.out_data  = r_q0;
  assign w_pop = bus.out_valid && bus.out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_ld0_new   = 1'b0;
    w_ld1_new   = 1'b0;
    w_ld0_q1    = 1'b0;
    unique case (r_state)
      S_EMPTY: begin
        if (w_grant) begin
          w_state_nxt = S_ONE;
          w_ld0_new   = 1'b1;
        end
      end
      S_ONE: begin
        if (w_grant && w_pop) begin
          w_ld0_new = 1'b1;
        end else if (w_grant) begin
          w_state_nxt = S_FULL;
          w_ld1_new   = 1'b1;
        end else if (w_pop) begin
          w_state_nxt = S_EMPTY;
        end
      end
      S_FULL: begin
        if (w_pop) begin
          w_state_nxt = S_ONE;
          w_ld0_q1    = 1'b1;
        end
      end
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_EMPTY;
      r_q0     <= '0;
      r_q1     <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_ld0_new) r_q0 <= w_word;
      if (w_ld0_q1)  r_q0 <= r_q1;
      if (w_ld1_new) r_q1 <= w_word;
      if (w_grant)   r_rr_ptr <= w_rr_nxt;
    end
  end

  always_comb begin
    w_dup = 1'b0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      for (int j = i + 1; j < NUM_INPUTS; j++) begin
        if (w_en[i] && w_en[j] && w_tag[i] == w_tag[j])
          w_dup = 1'b1;
      end
    end
  end

  assign w_dis = |(bus.in_valid & ~w_en);
  assign w_err = w_dup || w_dis;

  // Smallest code wins when both fire.
  always_comb begin
    w_err_code = 16'h0000;
    if (w_dup)
      w_err_code = CFG_TEMPORAL_MUX_DUP_TAG;
    else if (w_dis)
      w_err_code = RT_TEMPORAL_MUX_DISABLED_INPUT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_valid <= 1'b0;
      r_err_code  <= 16'h0000;
    end else if (w_err && !r_err_valid) begin
      r_err_valid <= 1'b1;
      r_err_code  <= w_err_code;
    end
  end

  assign bus.error_valid = r_err_valid;
  assign bus.error_code  = r_err_code;

endmodule

// File: tb/tb_fabric_temporal_mux.sv
// Directed self-checking bench for fabric_temporal_mux
// (rotation, backpressure, pointer, errors, async reset).
module tb_fabric_temporal_mux;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int TW = 4;

  localparam logic [15:0] E_DUP = 16'h0021;
  localparam logic [15:0] E_DIS = 16'h1021;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  fabric_temporal_mux_if #(
    .NUM_INPUTS(N), .DATA_WIDTH(DW), .TAG_WIDTH(TW)
  ) bus ();

  fabric_temporal_mux #(
    .NUM_INPUTS(N), .DATA_WIDTH(DW), .TAG_WIDTH(TW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [19:0] mk_cfg(
    input logic [3:0] en,
    input logic [3:0] t0, input logic [3:0] t1,
    input logic [3:0] t2, input logic [3:0] t3
  );
    return {en[3], t3, en[2], t2, en[1], t1, en[0], t0};
  endfunction

  function automatic logic [35:0] word(
    input logic [3:0] t, input logic [31:0] d
  );
    return {t, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(
    input logic [31:0] d0, input logic [31:0] d1,
    input logic [31:0] d2, input logic [31:0] d3
  );
    bus.in_data = {d3, d2, d1, d0};
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.cfg_data = mk_cfg(4'hF, 4'd3, 4'd2, 4'd1, 4'd0);
    bus.in_valid = 4'hF;
    bus.out_ready = 1'b1;
    set_data(32'hA000_0000, 32'hA000_0001,
             32'hA000_0002, 32'hA000_0003);
    repeat (2) tick();
    n_chk++;
    if (bus.in_ready !== 4'h0) begin
      n_fail++;
      $display("FAIL rst_in_ready got %h want 0", bus.in_ready);
    end
    n_chk++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 36'h0) begin
      n_fail++;
      $display("FAIL rst_out got v=%b d=%h want 0/0",
               bus.out_valid, bus.out_data);
    end
    n_chk++;
    if (bus.error_valid !== 1'b0 || bus.error_code !== 16'h0) begin
      n_fail++;
      $display("FAIL rst_err got v=%b c=%h want 0/0",
               bus.error_valid, bus.error_code);
    end
    bus.in_valid = 4'h0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_rotation();
    logic [3:0] tags [4];
    tags = '{4'd3, 4'd2, 4'd1, 4'd0};
    bus.in_valid = 4'hF;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      int l;
      l = c % 4;
      #1;
      n_chk++;
      if (bus.in_ready !== 4'(1 << l)) begin
        n_fail++;
        $display("FAIL rot_grant[%0d] got %b want %b",
                 c, bus.in_ready, 4'(1 << l));
      end
      tick();
      n_chk++;
      if (bus.out_valid !== 1'b1 ||
          bus.out_data !== word(tags[l], 32'hA000_0000 + l)) begin
        n_fail++;
        $display("FAIL rot_out[%0d] got v=%b d=%h want 1/%h",
                 c, bus.out_valid, bus.out_data,
                 word(tags[l], 32'hA000_0000 + l));
      end
    end
    bus.in_valid = 4'h0;
    n_chk++;
    if (bus.error_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rot_err got %b want 0", bus.error_valid);
    end
    tick();
    n_chk++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rot_drain got %b want 0", bus.out_valid);
    end
  endtask

  task automatic test_backpressure();
    bus.cfg_data = mk_cfg(4'hF, 4'd3, 4'd5, 4'd1, 4'd0);
    set_data(32'hA000_0000, 32'hDEAD_BEEF,
             32'hA000_0002, 32'hA000_0003);
    bus.in_valid = 4'b0010;
    bus.out_ready = 1'b0;
    #1;
    n_chk++;
    if (bus.in_ready !== 4'b0010) begin
      n_fail++;
      $display("FAIL bp_grant0 got %b want 0010", bus.in_ready);
    end
    tick();
    set_data(32'hA000_0000, 32'hDEAD_BEF0,
             32'hA000_0002, 32'hA000_0003);
    #1;
    n_chk++;
    if (bus.in_ready !== 4'b0010 ||
        bus.out_data !== word(4'd5, 32'hDEAD_BEEF)) begin
      n_fail++;
      $display("FAIL bp_one got r=%b d=%h want 0010/%h",
               bus.in_ready, bus.out_data,
               word(4'd5, 32'hDEAD_BEEF));
    end
    for (int c = 0; c < 2; c++) begin
      tick();
      n_chk++;
      if (bus.in_ready !== 4'b0000 || bus.out_valid !== 1'b1 ||
          bus.out_data !== word(4'd5, 32'hDEAD_BEEF)) begin
        n_fail++;
        $display("FAIL bp_full[%0d] got r=%b v=%b d=%h want 0000/1/%h",
                 c, bus.in_ready, bus.out_valid, bus.out_data,
                 word(4'd5, 32'hDEAD_BEEF));
      end
    end
    bus.in_valid = 4'h0;
    bus.out_ready = 1'b1;
    tick();
    n_chk++;
    if (bus.out_valid !== 1'b1 ||
        bus.out_data !== word(4'd5, 32'hDEAD_BEF0)) begin
      n_fail++;
      $display("FAIL bp_drain1 got v=%b d=%h want 1/%h",
               bus.out_valid, bus.out_data,
               word(4'd5, 32'hDEAD_BEF0));
    end
    tick();
    n_chk++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_drain2 got %b want 0", bus.out_valid);
    end
  endtask

  task automatic test_rr_pointer();
    set_data(32'hA000_0000, 32'hA000_0001,
             32'hA000_0002, 32'hA000_0003);
    bus.in_valid = 4'b0001;
    #1;
    n_chk++;
    if (bus.in_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL rr_seed got %b want 0001", bus.in_ready);
    end
    tick();
    bus.in_valid = 4'b0101;
    #1;
    n_chk++;
    if (bus.in_ready !== 4'b0100) begin
      n_fail++;
      $display("FAIL rr_first got %b want 0100", bus.in_ready);
    end
    tick();
    n_chk++;
    if (bus.out_data !== word(4'd1, 32'hA000_0002) ||
        bus.in_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL rr_second got d=%h r=%b want %h/0001",
               bus.out_data, bus.in_ready,
               word(4'd1, 32'hA000_0002));
    end
    tick();
    bus.in_valid = 4'h0;
    n_chk++;
    if (bus.out_data !== word(4'd3, 32'hA000_0000)) begin
      n_fail++;
      $display("FAIL rr_out got %h want %h", bus.out_data,
               word(4'd3, 32'hA000_0000));
    end
    tick();
    n_chk++;
    if (bus.error_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rr_err got %b want 0", bus.error_valid);
    end
  endtask

  task automatic test_disabled_lane();
    bus.cfg_data = mk_cfg(4'b1011, 4'd3, 4'd5, 4'd1, 4'd0);
    bus.in_valid = 4'b0101;
    bus.out_ready = 1'b1;
    #1;
    n_chk++;
    if (bus.in_ready !== 4'b0001 || bus.error_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL dis_grant got r=%b e=%b want 0001/0",
               bus.in_ready, bus.error_valid);
    end
    tick();
    n_chk++;
    if (bus.error_valid !== 1'b1 || bus.error_code !== E_DIS) begin
      n_fail++;
      $display("FAIL dis_err got v=%b c=%h want 1/%h",
               bus.error_valid, bus.error_code, E_DIS);
    end
    n_chk++;
    if (bus.out_data !== word(4'd3, 32'hA000_0000) ||
        bus.in_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL dis_flow got d=%h r=%b want %h/0001",
               bus.out_data, bus.in_ready,
               word(4'd3, 32'hA000_0000));
    end
    tick();
    n_chk++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL dis_flow2 got v=%b r=%b want 1/0001",
               bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset_midop();
    bus.out_ready = 1'b0;
    tick();
    tick();
    n_chk++;
    if (bus.in_ready !== 4'b0000 || bus.out_valid !== 1'b1 ||
        bus.error_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_full got r=%b v=%b e=%b want 0000/1/1",
               bus.in_ready, bus.out_valid, bus.error_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (bus.out_valid !== 1'b0 || bus.error_valid !== 1'b0 ||
        bus.error_code !== 16'h0 || bus.in_ready !== 4'h0) begin
      n_fail++;
      $display("FAIL mid_rst got v=%b e=%b c=%h r=%b want 0/0/0/0",
               bus.out_valid, bus.error_valid,
               bus.error_code, bus.in_ready);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    bus.cfg_data = mk_cfg(4'hF, 4'd3, 4'd2, 4'd1, 4'd0);
    bus.in_valid = 4'hF;
    bus.out_ready = 1'b1;
    #1;
    n_chk++;
    if (bus.in_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL mid_grant got %b want 0001", bus.in_ready);
    end
    tick();
    n_chk++;
    if (bus.out_data !== word(4'd3, 32'hA000_0000)) begin
      n_fail++;
      $display("FAIL mid_out got %h want %h", bus.out_data,
               word(4'd3, 32'hA000_0000));
    end
  endtask

  task automatic test_dup_tag();
    bus.cfg_data = mk_cfg(4'b1101, 4'd7, 4'd2, 4'd1, 4'd7);
    bus.in_valid = 4'hF;
    #1;
    n_chk++;
    if (bus.error_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL dup_pre got %b want 0", bus.error_valid);
    end
    tick();
    n_chk++;
    if (bus.error_valid !== 1'b1 || bus.error_code !== E_DUP) begin
      n_fail++;
      $display("FAIL dup_err got v=%b c=%h want 1/%h",
               bus.error_valid, bus.error_code, E_DUP);
    end
    bus.cfg_data = mk_cfg(4'b1011, 4'd3, 4'd2, 4'd1, 4'd0);
    tick();
    tick();
    n_chk++;
    if (bus.error_valid !== 1'b1 || bus.error_code !== E_DUP ||
        bus.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL dup_sticky got v=%b c=%h o=%b want 1/%h/1",
               bus.error_valid, bus.error_code,
               bus.out_valid, E_DUP);
    end
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst_n = 1'b0;
    bus.in_valid = '0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    bus.cfg_data = '0;
    test_reset();
    test_rotation();
    test_backpressure();
    test_rr_pointer();
    test_disabled_lane();
    test_reset_midop();
    test_dup_tag();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
